// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding, oversampling ratio,
// parity selection and data-width decode.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic        PARITY_EVEN = 1'b0;
  localparam logic        PARITY_ODD  = 1'b1;
  localparam int unsigned OVERSAMPLE  = 16;

  // 00=5, 01=6, 10=7, 11=8 data bits
  function automatic logic [3:0] num_data_bits(input logic [1:0] data_bit_num);
    return 4'd5 + {2'b00, data_bit_num};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous serial input; resets to the
// idle-high line level so no false start edge appears out of reset.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled frame recovery (5-8 data bits, optional parity,
// 1-2 stop bits) feeding a one-entry valid/ready buffer with rts_n flow control.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rts_n
);

  localparam logic [3:0] SAMPLE_CNT = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] HALF_CNT   = 4'(OVERSAMPLE / 2 - 1);

  logic       rxs;
  rx_state_t  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_err_q, par_err_d;
  logic       stop_err_q, stop_err_d;
  logic       armed_q, armed_d;
  logic [1:0] dbn_q, dbn_d;
  logic       stop2_q, stop2_d;
  logic       pen_q, pen_d;
  logic       ptype_q, ptype_d;

  logic       sample, last_data, frame_done, frame_err_new;

  logic [7:0] rx_data_q;
  logic       rx_valid_q, parity_err_q, frame_err_q, overrun_q;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      armed_q    <= 1'b0;
      dbn_q      <= '0;
      stop2_q    <= 1'b0;
      pen_q      <= 1'b0;
      ptype_q    <= PARITY_EVEN;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      armed_q    <= armed_d;
      dbn_q      <= dbn_d;
      stop2_q    <= stop2_d;
      pen_q      <= pen_d;
      ptype_q    <= ptype_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    armed_d    = armed_q;
    dbn_d      = dbn_q;
    stop2_d    = stop2_q;
    pen_d      = pen_q;
    ptype_d    = ptype_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (armed_q && !rxs) begin
            state_d    = START;
            tick_cnt_d = '0;
            shift_d    = '0;
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
            dbn_d      = data_bit_num;
            stop2_d    = stop_bit_num;
            pen_d      = parity_en;
            ptype_d    = parity_type;
          end else if (rxs) begin
            armed_d = 1'b1;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_CNT) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rxs ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        DATA: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (sample) begin
            shift_d[bit_cnt_q] = rxs;
            if (last_data) begin
              state_d    = pen_q ? PARITY : STOP;
              stop_cnt_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        PARITY: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (sample) begin
            par_err_d  = ((^shift_q) ^ rxs) != ptype_q;
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end
        end
        STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (sample) begin
            if (!rxs) stop_err_d = 1'b1;
            if (stop_cnt_q == stop2_q) begin
              // Staying armed after a clean stop lets a start edge on the very next tick begin a frame.
              state_d = IDLE;
              armed_d = rxs && !stop_err_q;
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sample        = tick && (tick_cnt_q == SAMPLE_CNT);
    last_data     = ({1'b0, bit_cnt_q} == (num_data_bits(dbn_q) - 4'd1));
    frame_done    = sample && (state_q == STOP) && (stop_cnt_q == stop2_q);
    frame_err_new = stop_err_q | ~rxs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q    <= shift_q;
          parity_err_q <= par_err_q;
          frame_err_q  <= frame_err_new;
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rts_n       = rx_valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames tick-accurately and
// compares accepted frames against a frame-level reference model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n, tick, rx;
  logic [1:0] data_bit_num;
  logic       stop_bit_num, parity_en, parity_type, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, rts_n;

  int errors = 0;
  int checks = 0;
  int ovr_cnt = 0;
  logic [9:0] got[$];
  logic [9:0] exp[$];

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .rx           (rx),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .rts_n        (rts_n)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Every accepted frame is logged as {parity_err, frame_err, data}.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) got.push_back({parity_err, frame_err, rx_data});
    if (rst_n && overrun_err) ovr_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame-level model: data truncated to the configured width; parity error when
  // the ones count over data plus the transmitted parity bit misses the chosen sense.
  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] dbn,
                                       input logic pen, input logic ptype,
                                       input logic flip, input logic stop0);
    int unsigned n = 5 + int'(dbn);
    int unsigned v = int'(d) % (1 << n);
    int unsigned ones = $countones(v);
    int unsigned pbit = ((ones % 2) ^ int'(ptype) ^ int'(flip)) & 1;
    logic perr = pen && (((ones + pbit) % 2) != int'(ptype));
    logic [7:0] dv = v[7:0];
    return {perr, stop0, dv};
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] dbn, input logic stop2,
                            input logic pen, input logic ptype, input logic flip,
                            input logic stop0, output logic lat_prev, output logic lat_valid);
    int n = 5 + int'(dbn);
    int ones = 0;
    data_bit_num = dbn;
    stop_bit_num = stop2;
    parity_en    = pen;
    parity_type  = ptype;
    rx = 1'b0;
    wait_ticks(2);
    {data_bit_num, stop_bit_num, parity_en, parity_type} = 5'($urandom);
    wait_ticks(14);
    for (int i = 0; i < n; i++) begin
      rx = d[i];
      ones += int'(d[i]);
      wait_ticks(16);
    end
    if (pen) begin
      rx = logic'(ones % 2) ^ ptype ^ flip;
      wait_ticks(16);
    end
    lat_prev = 1'b0;
    lat_valid = 1'b0;
    for (int s = 0; s <= int'(stop2); s++) begin
      rx = (s == 0 && stop0) ? 1'b0 : 1'b1;
      if (s == int'(stop2)) begin
        wait_ticks(8);
        lat_prev = rx_valid;
        wait_ticks(1);
        lat_valid = rx_valid;
        wait_ticks(7);
      end else begin
        wait_ticks(16);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b1;
    {data_bit_num, stop_bit_num, parity_en, parity_type} = '0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", overrun_err); end
    checks++; if (rts_n !== 1'b0) begin errors++; $display("FAIL reset_rts got=%b exp=0", rts_n); end
    wait_ticks(20);
  endtask

  task automatic test_8n1;
    logic lp, lv;
    logic [9:0] g;
    got.delete();
    send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lp, lv);
    checks++; if (lp !== 1'b0) begin errors++; $display("FAIL lat_early got=%b exp=0", lp); end
    checks++; if (lv !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b exp=1", lv); end
    checks++; if (rx_valid !== 1'b0 || rts_n !== 1'b0) begin
      errors++; $display("FAIL 8n1_release got valid=%b rts_n=%b exp 0/0", rx_valid, rts_n);
    end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL 8n1_count got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      g = got.pop_front();
      checks++; if (g !== model(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0)) begin
        errors++; $display("FAIL 8n1_frame got=%h exp=%h", g, model(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_parity;
    logic lp, lv;
    logic [9:0] g;
    got.delete(); exp.delete();
    send_frame(8'h13, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, lp, lv);
    exp.push_back(10'h013);
    send_frame(8'h13, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, lp, lv);
    exp.push_back(10'h213);
    wait_ticks(4);
    checks++; if (got.size() != exp.size()) begin
      errors++; $display("FAIL parity_count got=%0d exp=%0d", got.size(), exp.size());
    end
    while (got.size() > 0 && exp.size() > 0) begin
      g = got.pop_front();
      checks++; if (g !== exp[0]) begin errors++; $display("FAIL parity_frame got=%h exp=%h", g, exp[0]); end
      void'(exp.pop_front());
    end
  endtask

  task automatic test_glitch;
    logic lp, lv;
    logic [9:0] g;
    got.delete();
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    checks++; if (got.size() != 0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL glitch_reject got frames=%0d valid=%b exp 0/0", got.size(), rx_valid);
    end
    got.delete();
    send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lp, lv);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL glitch_count got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      g = got.pop_front();
      checks++; if (g !== 10'h03C) begin errors++; $display("FAIL glitch_frame got=%h exp=03c", g); end
    end
  endtask

  task automatic test_overrun;
    logic lp, lv;
    int ovr0;
    logic [9:0] g;
    got.delete();
    rx_ready = 1'b0;
    send_frame(8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lp, lv);
    checks++; if (rx_valid !== 1'b1 || rts_n !== 1'b1 || rx_data !== 8'h11) begin
      errors++; $display("FAIL hold_first got valid=%b rts_n=%b data=%h exp 1/1/11", rx_valid, rts_n, rx_data);
    end
    ovr0 = ovr_cnt;
    send_frame(8'h22, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lp, lv);
    checks++; if (ovr_cnt - ovr0 != 1) begin errors++; $display("FAIL overrun_pulse got=%0d clks exp=1", ovr_cnt - ovr0); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      errors++; $display("FAIL overrun_keep got valid=%b data=%h exp 1/11", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rx_valid !== 1'b0 || rts_n !== 1'b0) begin
      errors++; $display("FAIL drain_valid got valid=%b rts_n=%b exp 0/0", rx_valid, rts_n);
    end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL drain_count got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      g = got.pop_front();
      checks++; if (g !== 10'h011) begin errors++; $display("FAIL drain_frame got=%h exp=011", g); end
    end
  endtask

  task automatic test_frame_err;
    logic lp, lv;
    logic [9:0] g;
    got.delete(); exp.delete();
    send_frame(8'h55, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, lp, lv);
    exp.push_back(model(8'h55, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1));
    wait_ticks(640);
    rx = 1'b1;
    wait_ticks(32);
    send_frame(8'h0F, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, lp, lv);
    exp.push_back(model(8'h0F, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0));
    wait_ticks(4);
    checks++; if (got.size() != exp.size()) begin
      errors++; $display("FAIL break_count got=%0d exp=%0d", got.size(), exp.size());
    end
    while (got.size() > 0 && exp.size() > 0) begin
      g = got.pop_front();
      checks++; if (g !== exp[0]) begin errors++; $display("FAIL break_frame got=%h exp=%h", g, exp[0]); end
      void'(exp.pop_front());
    end
  endtask

  task automatic test_back_to_back;
    logic lp, lv;
    logic [9:0] g;
    logic [7:0] d;
    logic [1:0] dbn;
    logic s2, pen, pt, fl;
    int ovr0 = ovr_cnt;
    got.delete(); exp.delete();
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom); dbn = 2'($urandom); s2 = 1'($urandom);
      pen = 1'($urandom); pt = 1'($urandom); fl = 1'($urandom);
      send_frame(d, dbn, s2, pen, pt, fl, 1'b0, lp, lv);
      exp.push_back(model(d, dbn, pen, pt, fl, 1'b0));
    end
    wait_ticks(4);
    checks++; if (got.size() != exp.size()) begin
      errors++; $display("FAIL b2b_count got=%0d exp=%0d", got.size(), exp.size());
    end
    while (got.size() > 0 && exp.size() > 0) begin
      g = got.pop_front();
      checks++; if (g !== exp[0]) begin errors++; $display("FAIL b2b_frame got=%h exp=%h", g, exp[0]); end
      void'(exp.pop_front());
    end
    checks++; if (ovr_cnt != ovr0) begin errors++; $display("FAIL b2b_overrun got=%0d exp=0", ovr_cnt - ovr0); end
  endtask

  task automatic test_reset_mid;
    logic lp, lv;
    logic [9:0] g;
    rx_ready = 1'b0;
    send_frame(8'h15, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lp, lv);
    rx = 1'b0; wait_ticks(16);
    rx = 1'b1; wait_ticks(16);
    rx = 1'b0; wait_ticks(8);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rts_n !== 1'b0 ||
                  parity_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL async_reset got valid=%b data=%h rts_n=%b perr=%b ferr=%b exp all 0",
                         rx_valid, rx_data, rts_n, parity_err, frame_err);
    end
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    rx_ready = 1'b1;
    got.delete();
    wait_ticks(20);
    send_frame(8'h2A, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lp, lv);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL post_reset_count got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      g = got.pop_front();
      checks++; if (g !== 10'h02A) begin errors++; $display("FAIL post_reset_frame got=%h exp=02a", g); end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
